// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the MIPS front-end flow-control slice:
//   RESET_PC_DEFAULT  fetch address after reset
//   NOP_INST          encoding loaded into IF/ID on flush (sll $0,$0,0)
//   CTRL_W_DEFAULT    default width of the ID-stage control bundle
//   WD_RUN/WD_TRIPPED stall-watchdog state encoding
//   STALL_CNT_MAX     saturation value of the 8-bit stall counter
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam int          CTRL_W_DEFAULT   = 12;

  localparam logic [0:0]  WD_RUN           = 1'b0;
  localparam logic [0:0]  WD_TRIPPED       = 1'b1;

  localparam logic [7:0]  STALL_CNT_MAX    = 8'hFF;

endpackage

// File: rtl/pipe_flow_ctrl_stall_watchdog.sv
// -----------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive stall cycles and latches an error once the run length
// reaches MAX_STALL. The error is sticky until reset.
// Ports:
//   clk      pipeline clock, rising edge
//   rst_n    asynchronous active-low reset
//   stall_i  pipeline stalled this cycle
//   state_o  watchdog FSM state (WD_RUN / WD_TRIPPED), registered
//   count_o  current consecutive-stall count, saturating at 255
// -----------------------------------------------------------------------------
module stall_watchdog
  import pipe_pkg::*;
#(
  parameter int MAX_STALL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall_i,
  output logic [0:0] state_o,
  output logic [7:0] count_o
);

  localparam logic [7:0] LIMIT = 8'(MAX_STALL);

  logic [7:0] cnt_q, cnt_d;
  logic [0:0] state_q, state_d;

  // Run-length counter: any non-stall cycle restarts the run.
  always_comb begin
    cnt_d = 8'd0;
    if (stall_i) begin
      cnt_d = (cnt_q == STALL_CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // Trip on the edge that registers the LIMIT-th consecutive stall; cnt_d is
  // only non-zero while stalling, so the compare implies stall_i.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WD_RUN:     if (cnt_d >= LIMIT) state_d = WD_TRIPPED;
      WD_TRIPPED: state_d = WD_TRIPPED;
      default:    state_d = WD_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      state_q <= WD_RUN;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_flow_ctrl
// Front-end flow-control responder for the 5-stage MIPS pipeline. Owns the PC,
// the IF/ID register and the ID/EX control-field register, and applies the
// stall / redirect / bubble requests raised by the ID-stage hazard unit.
// Optional feature macro: PIPE_FLOW_PERF_EN adds three 32-bit wrapping event
// counters (perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt) with output ports.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   if_stall           hold PC and IF/ID (also bubbles ID/EX)
//   if_rst             redirect to redirect_pc and flush IF/ID
//   data_hazard        bubble ID/EX
//   redirect_pc        redirect target
//   imem_inst          instruction at pc (combinational imem)
//   id_ctrl            decoded control bundle of the instruction in ID
//   pc                 current fetch address
//   if_id_pc4/_inst/_valid   IF/ID register contents
//   id_ex_ctrl/_valid  ID/EX control register contents
//   stall_timeout      sticky watchdog error
// Handshake: no valid/ready pairs; if_stall is an unconditional hold that
// takes priority over if_rst, and data_hazard/if_stall both force a bubble.
// -----------------------------------------------------------------------------
module pipe_flow_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          CTRL_W    = CTRL_W_DEFAULT,
  parameter int          MAX_STALL = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_stall,
  input  logic              if_rst,
  input  logic              data_hazard,
  input  logic [31:0]       redirect_pc,
  input  logic [31:0]       imem_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_pc4,
  output logic [31:0]       if_id_inst,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_valid,
`ifdef PIPE_FLOW_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_bubble_cnt,
`endif
  output logic              stall_timeout
);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pc4_q, pc4_d;
  logic [31:0]       inst_q, inst_d;
  logic              ifv_q, ifv_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              exv_q, exv_d;

  logic [31:0] pc_plus4;
  logic        bubble;
  logic [0:0]  wd_state;
  logic [7:0]  wd_count;

  // Natural 32-bit add wraps 0xFFFF_FFFC to 0.
  assign pc_plus4 = pc_q + 32'd4;
  assign bubble   = data_hazard | if_stall;

  // Stall outranks redirect: a redirect raised during a stall is dropped and
  // re-raised by the hazard unit once the stall clears.
  always_comb begin
    pc_d   = pc_q;
    pc4_d  = pc4_q;
    inst_d = inst_q;
    ifv_d  = ifv_q;
    if (!if_stall) begin
      if (if_rst) begin
        pc_d   = redirect_pc;
        pc4_d  = 32'd0;
        inst_d = NOP_INST;
        ifv_d  = 1'b0;
      end else begin
        pc_d   = pc_plus4;
        pc4_d  = pc_plus4;
        inst_d = imem_inst;
        ifv_d  = 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_d = id_ctrl;
    exv_d  = ifv_q;
    if (bubble) begin
      ctrl_d = '0;
      exv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      pc4_q  <= 32'd0;
      inst_q <= NOP_INST;
      ifv_q  <= 1'b0;
      ctrl_q <= '0;
      exv_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      pc4_q  <= pc4_d;
      inst_q <= inst_d;
      ifv_q  <= ifv_d;
      ctrl_q <= ctrl_d;
      exv_q  <= exv_d;
    end
  end

  stall_watchdog #(
    .MAX_STALL(MAX_STALL)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (if_stall),
    .state_o (wd_state),
    .count_o (wd_count)
  );

  // wd_count is a debug tap only; fold it into a no-op so it stays observable.
  logic wd_count_unused;
  assign wd_count_unused = ^wd_count;

  assign pc            = pc_q;
  assign if_id_pc4     = pc4_q;
  assign if_id_inst    = inst_q;
  assign if_id_valid   = ifv_q;
  assign id_ex_ctrl    = ctrl_q;
  assign id_ex_valid   = exv_q;
  assign stall_timeout = (wd_state == WD_TRIPPED);

`ifdef PIPE_FLOW_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      flush_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (if_stall)           stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (if_rst && !if_stall) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (bubble)             bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_flow_ctrl
// Directed bench for pipe_flow_ctrl: a table of per-cycle input/expected-output
// records, followed by hand-written watchdog and mid-run reset sequences.
// Honours PIPE_FLOW_PERF_EN for the optional counter ports.
// -----------------------------------------------------------------------------
module tb_pipe_flow_ctrl;

  localparam int CTRL_W = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              if_stall, if_rst, data_hazard;
  logic [31:0]       redirect_pc, imem_inst;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       pc, if_id_pc4, if_id_inst;
  logic              if_id_valid, id_ex_valid, stall_timeout;
  logic [CTRL_W-1:0] id_ex_ctrl;
`ifdef PIPE_FLOW_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt;
`endif

  pipe_flow_ctrl #(
    .RESET_PC  (32'h0000_3000),
    .CTRL_W    (CTRL_W),
    .MAX_STALL (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_stall      (if_stall),
    .if_rst        (if_rst),
    .data_hazard   (data_hazard),
    .redirect_pc   (redirect_pc),
    .imem_inst     (imem_inst),
    .id_ctrl       (id_ctrl),
    .pc            (pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_inst    (if_id_inst),
    .if_id_valid   (if_id_valid),
    .id_ex_ctrl    (id_ex_ctrl),
    .id_ex_valid   (id_ex_valid),
`ifdef PIPE_FLOW_PERF_EN
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_bubble_cnt (perf_bubble_cnt),
`endif
    .stall_timeout (stall_timeout)
  );

  // Instruction memory model: a fixed scramble of the address.
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return a ^ 32'h2408_0000;
  endfunction
  assign imem_inst = imem_f(pc);

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              stall;
    logic              rst;
    logic              dh;
    logic [31:0]       rpc;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       e_pc;
    logic [31:0]       e_pc4;
    logic [31:0]       e_inst;
    logic              e_ifv;
    logic [CTRL_W-1:0] e_ctrl;
    logic              e_exv;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic s, input logic r, input logic d, input logic [31:0] rpc,
                         input logic [CTRL_W-1:0] c, input logic [31:0] epc,
                         input logic [31:0] epc4, input logic [31:0] einst, input logic eifv,
                         input logic [CTRL_W-1:0] ectrl, input logic eexv);
    vec_t v;
    v.stall = s; v.rst = r; v.dh = d; v.rpc = rpc; v.ctrl = c;
    v.e_pc = epc; v.e_pc4 = epc4; v.e_inst = einst; v.e_ifv = eifv;
    v.e_ctrl = ectrl; v.e_exv = eexv;
    vq.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic r, input logic d,
                       input logic [31:0] rpc, input logic [CTRL_W-1:0] c);
    if_stall = s; if_rst = r; data_hazard = d; redirect_pc = rpc; id_ctrl = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, '0);

    //       stall rst dh  redirect       ctrl    exp pc         exp pc4        exp inst                 ifv ctrl    exv
    add_vec(0, 0, 0, 32'h0,         12'h011, 32'h0000_3004, 32'h0000_3004, imem_f(32'h0000_3000), 1, 12'h011, 0);
    add_vec(0, 0, 0, 32'h0,         12'h022, 32'h0000_3008, 32'h0000_3008, imem_f(32'h0000_3004), 1, 12'h022, 1);
    add_vec(0, 0, 0, 32'h0,         12'h033, 32'h0000_300C, 32'h0000_300C, imem_f(32'h0000_3008), 1, 12'h033, 1);
    add_vec(0, 0, 0, 32'h0,         12'h044, 32'h0000_3010, 32'h0000_3010, imem_f(32'h0000_300C), 1, 12'h044, 1);
    // load-use at 0x3010
    add_vec(1, 0, 1, 32'h0,         12'h055, 32'h0000_3010, 32'h0000_3010, imem_f(32'h0000_300C), 1, 12'h000, 0);
    add_vec(0, 0, 0, 32'h0,         12'h066, 32'h0000_3014, 32'h0000_3014, imem_f(32'h0000_3010), 1, 12'h066, 1);
    // jump to 0x3100
    add_vec(0, 1, 0, 32'h0000_3100, 12'h077, 32'h0000_3100, 32'h0,         32'h0,                 0, 12'h077, 1);
    add_vec(0, 0, 0, 32'h0,         12'h088, 32'h0000_3104, 32'h0000_3104, imem_f(32'h0000_3100), 1, 12'h088, 0);
    // stall and redirect together: stall wins
    add_vec(1, 1, 0, 32'h0000_3200, 12'h099, 32'h0000_3104, 32'h0000_3104, imem_f(32'h0000_3100), 1, 12'h000, 0);
    add_vec(0, 1, 0, 32'h0000_3200, 12'h0AA, 32'h0000_3200, 32'h0,         32'h0,                 0, 12'h0AA, 1);
    // data hazard alone: bubble but fetch proceeds
    add_vec(0, 0, 1, 32'h0,         12'h0BB, 32'h0000_3204, 32'h0000_3204, imem_f(32'h0000_3200), 1, 12'h000, 0);
    // wrap-around
    add_vec(0, 1, 0, 32'hFFFF_FFF8, 12'h0CC, 32'hFFFF_FFF8, 32'h0,         32'h0,                 0, 12'h0CC, 1);
    add_vec(0, 0, 0, 32'h0,         12'h0DD, 32'hFFFF_FFFC, 32'hFFFF_FFFC, imem_f(32'hFFFF_FFF8), 1, 12'h0DD, 0);
    add_vec(0, 0, 0, 32'h0,         12'h0EE, 32'h0000_0000, 32'h0000_0000, imem_f(32'hFFFF_FFFC), 1, 12'h0EE, 1);
    add_vec(0, 0, 0, 32'h0,         12'h0FF, 32'h0000_0004, 32'h0000_0004, imem_f(32'h0000_0000), 1, 12'h0FF, 1);

    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_pc",      pc,                    32'h0000_3000);
    check("rst_pc4",     if_id_pc4,             32'h0);
    check("rst_inst",    if_id_inst,            32'h0);
    check("rst_ifv",     32'(if_id_valid),      32'h0);
    check("rst_ctrl",    32'(id_ex_ctrl),       32'h0);
    check("rst_exv",     32'(id_ex_valid),      32'h0);
    check("rst_timeout", 32'(stall_timeout),    32'h0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].rst, vq[i].dh, vq[i].rpc, vq[i].ctrl);
      step();
      check($sformatf("v%0d_pc", i),      pc,                   vq[i].e_pc);
      check($sformatf("v%0d_pc4", i),     if_id_pc4,            vq[i].e_pc4);
      check($sformatf("v%0d_inst", i),    if_id_inst,           vq[i].e_inst);
      check($sformatf("v%0d_ifv", i),     32'(if_id_valid),     32'(vq[i].e_ifv));
      check($sformatf("v%0d_ctrl", i),    32'(id_ex_ctrl),      32'(vq[i].e_ctrl));
      check($sformatf("v%0d_exv", i),     32'(id_ex_valid),     32'(vq[i].e_exv));
      check($sformatf("v%0d_timeout", i), 32'(stall_timeout),   32'h0);
    end

`ifdef PIPE_FLOW_PERF_EN
    // stalls: v4,v8; accepted redirects: v6,v9,v11; bubbles: v4,v8,v10
    check("perf_stall",  perf_stall_cnt,  32'd2);
    check("perf_flush",  perf_flush_cnt,  32'd3);
    check("perf_bubble", perf_bubble_cnt, 32'd3);
`endif

    // Watchdog: a run of 7 stalls, a break, then another 7 -- never trips.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 12'h123);
    repeat (7) step();
    check("wd_run7_timeout", 32'(stall_timeout), 32'h0);
    check("wd_run7_pc_hold", pc, 32'h0000_0004);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 12'h123);
    step();
    check("wd_break_pc", pc, 32'h0000_0008);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 12'h123);
    repeat (7) step();
    check("wd_second7_timeout", 32'(stall_timeout), 32'h0);
    // Eighth consecutive stall trips it on that edge.
    step();
    check("wd_8th_timeout", 32'(stall_timeout), 32'h1);
    check("wd_8th_exv", 32'(id_ex_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 12'h456);
    step();
    check("wd_sticky_timeout", 32'(stall_timeout), 32'h1);
    check("wd_flow_pc", pc, 32'h0000_000C);
    check("wd_flow_ctrl", 32'(id_ex_ctrl), 32'h456);

    // Asynchronous reset mid-cycle, no clock edge needed.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",      pc,                 32'h0000_3000);
    check("arst_ifv",     32'(if_id_valid),   32'h0);
    check("arst_exv",     32'(id_ex_valid),   32'h0);
    check("arst_timeout", 32'(stall_timeout), 32'h0);
`ifdef PIPE_FLOW_PERF_EN
    check("arst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 12'h789);
    step();
    check("post_rst_pc",   pc,         32'h0000_3004);
    check("post_rst_inst", if_id_inst, imem_f(32'h0000_3000));
    check("post_rst_ifv",  32'(if_id_valid), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
